layer_arbiter: RTL and testbench

- Registered per-pixel arbiter that decides which of N_OBJS graphic objects drives the 3-bit VGA rgb bus, or whether the background does.
- Sits between the object generators (each supplies an on flag and r/g/b bits) and the VGA output pin register.
- Adds a programmable priority order, per-object enable and blink masks, and a config handshake.
- New config takes effect only at a frame boundary, so a frame never shows mixed settings.

---
 rtl/layer_arbiter_pkg.sv | 8 +
 rtl/layer_arbiter_prio_select.sv | 25 ++
 rtl/layer_arbiter.sv | 85 ++++++++
 tb/tb_layer_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/layer_arbiter_pkg.sv
// layer_arbiter_pkg: shared graphics constants and config FSM encoding
package layer_arbiter_pkg;
  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;
  localparam logic [2:0] BLACK = 3'b000;
  typedef enum logic {IDLE, PENDING} cfg_state_t;
endpackage

// File: rtl/layer_arbiter_prio_select.sv
// prio_select: rotating-priority encoder, first hit at or after top wins
module prio_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         hit,
  input  logic [$clog2(N)-1:0] top,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);
  localparam int TW = $clog2(N);
  logic [TW-1:0] idx;
  // scan from lowest priority to highest so the highest-priority hit is written last
  always_comb begin
    found = 1'b0;
    index = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = TW'((int'(top) + k) % N);
      if (hit[idx]) begin
        found = 1'b1;
        index = idx;
      end
    end
  end
endmodule

// File: rtl/layer_arbiter.sv
// layer_arbiter: per-pixel object/background arbiter with frame-synchronous config
module layer_arbiter
  import layer_arbiter_pkg::*;
#(
  parameter int N_OBJS = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pixel_tick,
  input  logic                      video_on,
  input  logic                      frame_start,
  input  logic [N_OBJS-1:0]         on_objs,
  input  logic [N_OBJS-1:0]         r_objs,
  input  logic [N_OBJS-1:0]         g_objs,
  input  logic [N_OBJS-1:0]         b_objs,
  input  logic [2:0]                bg_rgb,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(N_OBJS)-1:0] cfg_top,
  input  logic [N_OBJS-1:0]         cfg_enable,
  input  logic [N_OBJS-1:0]         cfg_blink,
  output logic [2:0]                rgb
);
  localparam int TW = $clog2(N_OBJS);
  localparam int CW = $clog2(BLINK_FRAMES) + 1;
  cfg_state_t state;
  logic [TW-1:0] top, pend_top, win;
  logic [N_OBJS-1:0] en, blink, pend_en, pend_blink, hit;
  logic [CW-1:0] cnt;
  logic phase, found, last_frame;
  logic [2:0] obj_rgb;
  assign hit = on_objs & en & ~(blink & {N_OBJS{phase}});
  assign last_frame = cnt == CW'(BLINK_FRAMES - 1);
  prio_select #(.N(N_OBJS)) u_prio (.hit(hit), .top(top), .found(found), .index(win));
  // colour of the winning object
  always_comb begin
    obj_rgb = BLACK;
    obj_rgb[R] = r_objs[win];
    obj_rgb[G] = g_objs[win];
    obj_rgb[B] = b_objs[win];
  end
  // config handshake: capture into pending, promote to active at a frame boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cfg_ready <= 1'b1;
      top <= '0;
      en <= '1;
      blink <= '0;
      pend_top <= '0;
      pend_en <= '1;
      pend_blink <= '0;
    end else if (state == IDLE) begin
      if (cfg_valid) begin
        pend_top <= 32'(cfg_top) >= N_OBJS ? '0 : cfg_top;
        pend_en <= cfg_enable;
        pend_blink <= cfg_blink;
        state <= PENDING;
        cfg_ready <= 1'b0;
      end
    end else if (frame_start) begin
      top <= pend_top;
      en <= pend_en;
      blink <= pend_blink;
      state <= IDLE;
      cfg_ready <= 1'b1;
    end
  end
  // blink phase toggles every BLINK_FRAMES frames
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      phase <= 1'b0;
    end else if (frame_start) begin
      cnt <= last_frame ? '0 : cnt + 1'b1;
      phase <= phase ^ last_frame;
    end
  end
  // output pixel register, updated only on pixel ticks
  always_ff @(posedge clk) begin
    if (!reset) rgb <= BLACK;
    else if (pixel_tick) rgb <= !video_on ? BLACK : found ? obj_rgb : bg_rgb;
  end
endmodule

// File: tb/tb_layer_arbiter.sv
// tb_layer_arbiter: directed and random checks against a frame-level reference model
module tb_layer_arbiter;
  localparam int N = 5;
  localparam int BF = 2;
  logic clk = 0, reset = 0, pixel_tick = 0, video_on = 0, frame_start = 0, cfg_valid = 0;
  logic [N-1:0] on_objs = 0, r_objs = 0, g_objs = 0, b_objs = 0, cfg_enable = 0, cfg_blink = 0;
  logic [2:0] bg_rgb = 0, cfg_top = 0, rgb;
  logic cfg_ready;
  int checks = 0, errors = 0;
  int m_top, p_top, nfr;
  logic [N-1:0] m_en, m_blink, p_en, p_blink;
  bit pend;
  logic [2:0] m_rgb;

  layer_arbiter #(.N_OBJS(N), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .frame_start(frame_start), .on_objs(on_objs), .r_objs(r_objs), .g_objs(g_objs),
    .b_objs(b_objs), .bg_rgb(bg_rgb), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_top(cfg_top), .cfg_enable(cfg_enable), .cfg_blink(cfg_blink), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_col(input int i, input logic [2:0] c);
    r_objs[i] = c[0];
    g_objs[i] = c[1];
    b_objs[i] = c[2];
  endtask

  // advance one clock: update the model from the current inputs, then compare
  task automatic step();
    logic [N-1:0] h;
    int w;
    bit ph;
    if (!reset) begin
      m_rgb = 0; m_top = 0; m_en = '1; m_blink = 0; pend = 0; nfr = 0;
    end else begin
      ph = ((nfr / BF) % 2) == 1;
      h = on_objs & m_en & ~(ph ? m_blink : '0);
      if (pixel_tick) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && h[(m_top + k) % N]) w = (m_top + k) % N;
        m_rgb = !video_on ? 3'b000 : w >= 0 ? {b_objs[w], g_objs[w], r_objs[w]} : bg_rgb;
      end
      if (pend && frame_start) begin
        m_top = p_top; m_en = p_en; m_blink = p_blink; pend = 0;
      end else if (!pend && cfg_valid) begin
        p_top = int'(cfg_top) >= N ? 0 : int'(cfg_top); p_en = cfg_enable; p_blink = cfg_blink; pend = 1;
      end
      if (frame_start) nfr++;
    end
    @(posedge clk);
    #1;
    chk("rgb", {5'b0, rgb}, {5'b0, m_rgb});
    chk("cfg_ready", {7'b0, cfg_ready}, {7'b0, !pend});
  endtask

  task automatic cfg(input logic [2:0] t, input logic [N-1:0] e, input logic [N-1:0] b, input logic fs);
    cfg_valid = 1; cfg_top = t; cfg_enable = e; cfg_blink = b; frame_start = fs;
    step();
    cfg_valid = 0; frame_start = 0;
  endtask

  task automatic frame();
    frame_start = 1; step(); frame_start = 0;
  endtask

  task automatic tick();
    pixel_tick = 1; step(); pixel_tick = 0;
  endtask

  initial begin
    step(); step();
    chk("reset_rgb", {5'b0, rgb}, 8'h0);
    chk("reset_ready", {7'b0, cfg_ready}, 8'h1);
    reset = 1;
    set_col(0, 3'b001); set_col(1, 3'b110);
    video_on = 1; on_objs = 5'b00011;
    tick();
    chk("t1_obj0", {5'b0, rgb}, 8'h1);
    cfg(3'd1, 5'h1F, 5'h00, 0);
    chk("t2_busy", {7'b0, cfg_ready}, 8'h0);
    tick();
    chk("t2_hold_old", {5'b0, rgb}, 8'h1);
    frame();
    chk("t2_ready_back", {7'b0, cfg_ready}, 8'h1);
    tick();
    chk("t2_obj1", {5'b0, rgb}, 8'h6);
    on_objs = 0; bg_rgb = 3'b010;
    tick();
    chk("t3_bg", {5'b0, rgb}, 8'h2);
    video_on = 0; bg_rgb = 3'b111;
    step(); step();
    chk("t3_hold", {5'b0, rgb}, 8'h2);
    tick();
    chk("t3_blank", {5'b0, rgb}, 8'h0);
    reset = 0; step(); reset = 1;
    cfg(3'd0, 5'h1F, 5'b00001, 0);
    frame(); frame();
    video_on = 1; on_objs = 5'b00001; bg_rgb = 3'b010;
    tick();
    chk("t4_blink_off", {5'b0, rgb}, 8'h2);
    frame(); frame();
    tick();
    chk("t4_blink_on", {5'b0, rgb}, 8'h1);
    cfg(3'd1, 5'h1F, 5'h00, 1);
    chk("t5_pending", {7'b0, cfg_ready}, 8'h0);
    cfg(3'd2, 5'h1F, 5'h00, 0);
    on_objs = 5'b00011;
    tick();
    chk("t5_not_yet", {5'b0, rgb}, 8'h1);
    frame();
    tick();
    chk("t5_applied", {5'b0, rgb}, 8'h6);
    cfg(3'd3, 5'h1F, 5'h00, 0);
    reset = 0; step();
    chk("t6_rgb", {5'b0, rgb}, 8'h0);
    chk("t6_ready", {7'b0, cfg_ready}, 8'h1);
    reset = 1;
    frame();
    tick();
    chk("t6_top0", {5'b0, rgb}, 8'h1);
    set_col(4, 3'b100); on_objs = 5'b10001;
    cfg(3'd7, 5'h1F, 5'h00, 0);
    frame();
    tick();
    chk("clamp_top", {5'b0, rgb}, 8'h1);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 199) != 0;
      pixel_tick = $urandom_range(0, 2) == 0;
      video_on = $urandom_range(0, 5) != 0;
      frame_start = $urandom_range(0, 15) == 0;
      cfg_valid = $urandom_range(0, 7) == 0;
      cfg_top = 3'($urandom_range(0, 7));
      cfg_enable = N'($urandom);
      cfg_blink = N'($urandom);
      on_objs = N'($urandom);
      r_objs = N'($urandom);
      g_objs = N'($urandom);
      b_objs = N'($urandom);
      bg_rgb = 3'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
